ysyx_23060136_ifu_bht: RTL
==========================

Name: ysyx_23060136_ifu_bht

Overview:
- Branch History Table in the IFU, directly upstream of the EXU branch-resolution stage.
- Every cycle it gives a taken/not-taken prediction for the fetch PC. That prediction travels down the pipe as EXU_i_pre_take.
- When EXU2 resolves a branch, the block takes the BHT_pc / BHT_pre_true / BHT_pre_false feedback and trains a 2-bit saturating counter.
- Direction only. The IFU predecode computes the predicted target (pc+imm).

Parameters:
- BITS_W, 32, PC width.
- IDX_W, 6, log2 of the entry count (64 entries). Index is pc[IDX_W+1:2].
- TAG_W, 8, tag width: pc[IDX_W+TAG_W+1:IDX_W+2]. Used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- IFU_pc  in  BITS_W  fetch PC to look up.
- IFU_pre_take  out  1  prediction for IFU_pc; 1 = taken.
- BHT_upd_en  in  1  EXU2 holds a valid, non-stalled control-transfer instruction. Asserted for exactly one cycle per instruction.
- BHT_pc  in  BITS_W  PC of the resolved instruction.
- BHT_pre_true  in  1  prediction was correct.
- BHT_pre_false  in  1  prediction was wrong.
- EXU_i_pre_take  in  1  prediction originally made for BHT_pc.
- BHT_hit  out  1  lookup tag hit. Tied to 1 without the optional feature.

Behaviour:
- Storage:
  - cnt[2^IDX_W], each 2 bits.
  - With the feature: also tag[2^IDX_W] and vld[2^IDX_W].
- Reset (synchronous, rst_n==0 at posedge):
  - all cnt = WNT (2'b01); all vld = 0.
  - IFU_pre_take is therefore 0 from the first cycle after reset.
  - A reset that coincides with BHT_upd_en discards the update.
- Lookup:
  - Purely combinational, zero latency.
  - IFU_pre_take = cnt[idx(IFU_pc)][1] & hit.
- Actual outcome: act_taken = EXU_i_pre_take ^ BHT_pre_false.
- Update trigger:
  - Effective when BHT_upd_en & (BHT_pre_true | BHT_pre_false).
  - Written at the next posedge; one update per cycle maximum.
- Counter next-state:
  - taken: SNT→WNT→WT→ST, saturating at ST (11).
  - not-taken: ST→WT→WNT→SNT, saturating at SNT (00).
  - No wrap-around.
- Same-cycle lookup and update to the same index: lookup returns the pre-update value. No bypass; the write becomes visible the following cycle.
- Illegal input: BHT_pre_true & BHT_pre_false both 1 → simulation assertion fires; the update is ignored.
- BHT_upd_en with neither flag set → no state change.
- Aliasing without the feature: distinct PCs sharing an index share one counter. This is accepted behaviour.
- Each update is a full read-modify-write of a single entry. Entries at other indices are untouched.

Optional Feature:
- Macro: YSYX_23060136_BHT_TAG_EN.
- Defined:
  - hit = vld[idx] & (tag[idx] == pc tag bits).
  - Update on tag hit: normal saturating update.
  - Update on tag miss or !vld (allocate): write tag, set vld = 1, cnt = act_taken ? WT : WNT.
- Undefined:
  - no tag/vld storage; hit = 1.
  - BHT_hit is tied to 1.

Decomposition:
- Package ysyx_23060136_bht_pkg:
  - counter typedef, bht_cnt_t = logic[1:0].
  - localparams SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - default IDX_W and TAG_W.
  - index/tag slice functions.
- Sub-module ysyx_23060136_bht_sat_cnt: combinational 2-bit saturating next-state (cur, taken → nxt). Reused by the top-level update path.

Test Plan:
- Reset, then sweep IFU_pc over 0x8000_0000..0x8000_00FC → IFU_pre_take = 0 for all; BHT_hit = 0 (TAG_EN) or 1.
- Two updates on pc 0x8000_0010, each with EXU_i_pre_take=0, pre_false=1 → counter WNT→WT→ST; lookup 0x8000_0010 gives 1 from the cycle after the first update.
- At ST, 5 taken updates → stays ST. Then 4 not-taken updates (pre_take=1, pre_false=1) → WT, WNT, SNT, SNT; prediction flips to 0 after the second.
- Update and lookup of the same index in one cycle → old value this cycle, new value next cycle. Update with rst_n=0 → counter remains WNT.
- TAG_EN: train 0x8000_0010 to ST, then look up alias 0x8000_1010 → pre_take 0, hit 0. One taken update at 0x8000_1010 → entry reallocated to WT; 0x8000_0010 now misses.
- BHT_upd_en=1 with pre_true=pre_false=1 → assertion fires, table unchanged. BHT_upd_en=0 with pre_false=1 → table unchanged.

Source files
------------

// File: rtl/ysyx_23060136_bht_pkg.sv
// Shared types, state encodings and PC slicing helpers for the IFU branch history table.
// The optional tagged mode is enabled by defining YSYX_23060136_BHT_TAG_EN.
package ysyx_23060136_bht_pkg;

   typedef logic [1:0] bht_cnt_t;

   localparam bht_cnt_t SNT = 2'b00;
   localparam bht_cnt_t WNT = 2'b01;
   localparam bht_cnt_t WT  = 2'b10;
   localparam bht_cnt_t ST  = 2'b11;

   localparam int BHT_IDX_W = 6;
   localparam int BHT_TAG_W = 8;

   // Instructions are word aligned, so the index field starts at bit 2.
   function automatic logic [31:0] bht_idx_field(input logic [31:0] pc);
      return pc >> 32'd2;
   endfunction

   // Tag bits sit directly above the index field.
   function automatic logic [31:0] bht_tag_field(input logic [31:0] pc, input int unsigned idx_w);
      return pc >> (idx_w + 32'd2);
   endfunction

endpackage

// File: rtl/ysyx_23060136_bht_chk.sv
// Simulation-only checker on the EXU2 feedback flags of the branch history table.
module ysyx_23060136_bht_chk (
   input logic clk,
   input logic rst_n,
   input logic upd_en,
   input logic pre_true,
   input logic pre_false
);

   // A resolved branch cannot be both correctly and wrongly predicted.
   always @(posedge clk) begin
      if (rst_n && upd_en) begin
         assert (!(pre_true && pre_false))
            else $warning("bht: pre_true and pre_false both set, update ignored");
      end
   end

endmodule

// File: rtl/ysyx_23060136_bht_sat_cnt.sv
// Combinational next-state for a 2-bit saturating direction counter.
module ysyx_23060136_bht_sat_cnt
   import ysyx_23060136_bht_pkg::*;
(
   input  bht_cnt_t cur,
   input  logic     taken,
   output bht_cnt_t nxt
);

   // Step one state toward the observed direction, holding at either end.
   always_comb begin
      nxt = cur;
      case (cur)
         SNT:     nxt = taken ? WNT : SNT;
         WNT:     nxt = taken ? WT  : SNT;
         WT:      nxt = taken ? ST  : WNT;
         ST:      nxt = taken ? ST  : WT;
         default: nxt = WNT;
      endcase
   end

endmodule

// File: rtl/ysyx_23060136_ifu_bht.sv
// IFU branch history table: 2-bit counters indexed by PC, zero-latency lookup, trained by EXU2.
// Define YSYX_23060136_BHT_TAG_EN to add per-entry tag/valid storage and allocate-on-miss.
module ysyx_23060136_ifu_bht
   import ysyx_23060136_bht_pkg::*;
#(
   parameter int BITS_W = 32,
   parameter int IDX_W  = BHT_IDX_W,
   parameter int TAG_W  = BHT_TAG_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [BITS_W-1:0] IFU_pc,
   output logic              IFU_pre_take,
   input  logic              BHT_upd_en,
   input  logic [BITS_W-1:0] BHT_pc,
   input  logic              BHT_pre_true,
   input  logic              BHT_pre_false,
   input  logic              EXU_i_pre_take,
   output logic              BHT_hit
);

   localparam int ENTRIES = 2 ** IDX_W;

   bht_cnt_t         cnt [ENTRIES];
   logic [IDX_W-1:0] look_idx;
   logic [IDX_W-1:0] upd_idx;
   logic             look_hit;
   logic             upd_hit;
   logic             act_taken;
   logic             upd_ok;
   bht_cnt_t         cur_cnt;
   bht_cnt_t         nxt_cnt;

   assign look_idx = IDX_W'(bht_idx_field(32'(IFU_pc)));
   assign upd_idx  = IDX_W'(bht_idx_field(32'(BHT_pc)));

   // Both flags set is illegal feedback; it trains nothing.
   assign act_taken = EXU_i_pre_take ^ BHT_pre_false;
   assign upd_ok    = BHT_upd_en & (BHT_pre_true ^ BHT_pre_false);
   assign cur_cnt   = cnt[upd_idx];

   ysyx_23060136_bht_sat_cnt u_sat (
      .cur   (cur_cnt),
      .taken (act_taken),
      .nxt   (nxt_cnt)
   );

`ifdef YSYX_23060136_BHT_TAG_EN
   logic [TAG_W-1:0] tag [ENTRIES];
   logic             vld [ENTRIES];
   logic [TAG_W-1:0] look_tag;
   logic [TAG_W-1:0] upd_tag;

   assign look_tag = TAG_W'(bht_tag_field(32'(IFU_pc), IDX_W));
   assign upd_tag  = TAG_W'(bht_tag_field(32'(BHT_pc), IDX_W));
   assign look_hit = vld[look_idx] && (tag[look_idx] == look_tag);
   assign upd_hit  = vld[upd_idx] && (tag[upd_idx] == upd_tag);

   // Train on a tag hit, otherwise reallocate the entry with a weak counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            cnt[i] <= WNT;
            vld[i] <= 1'b0;
         end
      end else if (upd_ok) begin
         if (upd_hit) begin
            cnt[upd_idx] <= nxt_cnt;
         end else begin
            tag[upd_idx] <= upd_tag;
            vld[upd_idx] <= 1'b1;
            cnt[upd_idx] <= act_taken ? WT : WNT;
         end
      end
   end
`else
   assign look_hit = 1'b1;
   assign upd_hit  = 1'b1;

   // Untagged: aliasing PCs share one counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            cnt[i] <= WNT;
         end
      end else if (upd_ok && upd_hit) begin
         cnt[upd_idx] <= nxt_cnt;
      end
   end
`endif

   // Lookup reads the table before any same-cycle write lands.
   assign IFU_pre_take = cnt[look_idx][1] & look_hit;
   assign BHT_hit      = look_hit;

   ysyx_23060136_bht_chk u_chk (
      .clk       (clk),
      .rst_n     (rst_n),
      .upd_en    (BHT_upd_en),
      .pre_true  (BHT_pre_true),
      .pre_false (BHT_pre_false)
   );

endmodule
